// File: rtl/write_back_queue_pkg.sv
// Shared CPU package: write-back queue defaults and the {addr, data} entry record
// used by the register file and datapath.
package write_back_queue_pkg;

    localparam int WBQ_DEPTH = 4;
    localparam int WBQ_AW    = 5;
    localparam int WBQ_DW    = 32;

    typedef struct packed {
        logic [WBQ_AW-1:0] addr;
        logic [WBQ_DW-1:0] data;
    } wbq_entry_t;

    // Occupancy counter width: must hold the value DEPTH itself.
    function automatic int wbq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/write_back_fwd_match.sv
// Youngest-match search over the pending write-back entries for one read port.
module write_back_fwd_match
    import write_back_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int AW    = WBQ_AW,
    parameter int DW    = WBQ_DW
) (
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [DEPTH-1:0][AW-1:0]   addr_mem,
    input  logic [DEPTH-1:0][DW-1:0]   data_mem,
    input  logic [AW-1:0]              ra,
    output logic                       hit,
    output logic [DW-1:0]              fwd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = wbq_cnt_w(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest from the head so the last match wins.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (ra != '0) && (addr_mem[idx] == ra)) begin
                hit = 1'b1;
                fwd = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/write_back_queue.sv
// Write-back queue: buffers register-file writes, drains one per cycle unless held,
// and forwards pending values to two read ports.
module write_back_queue
    import write_back_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int AW    = WBQ_AW,
    parameter int DW    = WBQ_DW
) (
    input  logic                     i_write_back_queue_clk,
    input  logic                     i_write_back_queue_rst,
    input  logic                     i_write_back_queue_valid,
    output logic                     o_write_back_queue_ready,
    input  logic [AW-1:0]            i_write_back_queue_addr,
    input  logic [DW-1:0]            i_write_back_queue_data,
    input  logic                     i_write_back_queue_hold,
    output logic                     o_write_back_queue_we,
    output logic [AW-1:0]            o_write_back_queue_writeAddr,
    output logic [DW-1:0]            o_write_back_queue_writeData,
    input  logic [AW-1:0]            i_write_back_queue_ra1,
    input  logic [AW-1:0]            i_write_back_queue_ra2,
    output logic                     o_write_back_queue_hit1,
    output logic                     o_write_back_queue_hit2,
    output logic [DW-1:0]            o_write_back_queue_fwd1,
    output logic [DW-1:0]            o_write_back_queue_fwd2,
    output logic [$clog2(DEPTH):0]   o_write_back_queue_count,
    output logic                     o_write_back_queue_empty
);

    localparam int             PW       = $clog2(DEPTH);
    localparam int             CW       = wbq_cnt_w(DEPTH);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]            count_q, count_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][AW-1:0] addr_mem;
    logic [DEPTH-1:0][DW-1:0] data_mem;
    logic                     empty;
    logic                     ready;
    logic                     push;
    logic                     pop;

    // Ready comes only from the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        empty    = (count_q == '0);
        ready    = (count_q < FULL_CNT);
        pop      = !empty && !i_write_back_queue_hold;
        push     = i_write_back_queue_valid && ready && (i_write_back_queue_addr != '0);
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_write_back_queue_clk) begin
        if (i_write_back_queue_rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never reset; every read of it is qualified by the occupancy count.
    always_ff @(posedge i_write_back_queue_clk) begin
        if (push && !i_write_back_queue_rst) begin
            addr_mem[wr_ptr_q] <= i_write_back_queue_addr;
            data_mem[wr_ptr_q] <= i_write_back_queue_data;
        end
    end

    assign o_write_back_queue_ready     = ready;
    assign o_write_back_queue_we        = pop;
    assign o_write_back_queue_writeAddr = empty ? '0 : addr_mem[rd_ptr_q];
    assign o_write_back_queue_writeData = empty ? '0 : data_mem[rd_ptr_q];
    assign o_write_back_queue_count     = count_q;
    assign o_write_back_queue_empty     = empty;

    write_back_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
        .head     (rd_ptr_q),
        .count    (count_q),
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .ra       (i_write_back_queue_ra1),
        .hit      (o_write_back_queue_hit1),
        .fwd      (o_write_back_queue_fwd1)
    );

    write_back_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
        .head     (rd_ptr_q),
        .count    (count_q),
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .ra       (i_write_back_queue_ra2),
        .hit      (o_write_back_queue_hit2),
        .fwd      (o_write_back_queue_fwd2)
    );

endmodule

// File: tb/tb_write_back_queue.sv
// Self-checking bench for write_back_queue: scoreboard of accepted entries checked
// against every register-file write, plus per-scenario inline checks.
module tb_write_back_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          hold;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] ra1, ra2;
    logic          hit1, hit2;
    logic [DW-1:0] fwd1, fwd2;
    logic [2:0]    count;
    logic          empty;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t sb[$];
    ent_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   accepted = 0;
    int   written  = 0;

    always #5 clk = ~clk;

    write_back_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .i_write_back_queue_clk       (clk),
        .i_write_back_queue_rst       (rst),
        .i_write_back_queue_valid     (valid),
        .o_write_back_queue_ready     (ready),
        .i_write_back_queue_addr      (addr),
        .i_write_back_queue_data      (data),
        .i_write_back_queue_hold      (hold),
        .o_write_back_queue_we        (we),
        .o_write_back_queue_writeAddr (waddr),
        .o_write_back_queue_writeData (wdata),
        .i_write_back_queue_ra1       (ra1),
        .i_write_back_queue_ra2       (ra2),
        .o_write_back_queue_hit1      (hit1),
        .o_write_back_queue_hit2      (hit2),
        .o_write_back_queue_fwd1      (fwd1),
        .o_write_back_queue_fwd2      (fwd2),
        .o_write_back_queue_count     (count),
        .o_write_back_queue_empty     (empty)
    );

    // Scoreboard: log accepted entries, compare each register-file write against the oldest.
    always @(negedge clk) begin
        if (!rst && we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_write unexpected write addr=%0d data=%h with nothing pending", waddr, wdata);
            end else begin
                mon_e = sb.pop_front();
                written++;
                if (waddr !== mon_e.a || wdata !== mon_e.d) begin
                    errors++;
                    $display("FAIL sb_write got addr=%0d data=%h expected addr=%0d data=%h",
                             waddr, wdata, mon_e.a, mon_e.d);
                end
            end
        end
        if (!rst && valid && ready && addr != '0) begin
            sb.push_back('{a: addr, d: data});
            accepted++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic offer(input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid = 1'b1;
        addr  = a;
        data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; hold = 1'b0; ra1 = '0; ra2 = '0; addr = '0; data = '0;
        tick();
        rst = 1'b0;
        sb.delete();
        samp();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", ready); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", we); end
        checks++; if (waddr !== '0 || wdata !== '0) begin errors++; $display("FAIL reset_wbus got addr=%0d data=%h exp 0/0", waddr, wdata); end
        checks++; if (hit1 !== 1'b0 || hit2 !== 1'b0 || fwd1 !== '0 || fwd2 !== '0) begin errors++; $display("FAIL reset_fwd got hit=%0b%0b fwd1=%h fwd2=%h exp all 0", hit1, hit2, fwd1, fwd2); end
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL reset_count got count=%0d empty=%0b exp 0/1", count, empty); end
    endtask

    task automatic test_single();
        tick();
        offer(5'd3, 32'hAAAA_0001);
        tick();
        valid = 1'b0;
        samp();
        checks++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hAAAA_0001) begin errors++; $display("FAIL single_write got we=%0b addr=%0d data=%h exp 1/3/aaaa0001", we, waddr, wdata); end
        tick();
        samp();
        checks++; if (empty !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL single_empty got empty=%0b we=%0b exp 1/0", empty, we); end
    endtask

    task automatic test_hold_full();
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(AW'(i), 32'h100 + 32'(i));
            tick();
        end
        offer(5'd5, 32'h105);
        samp();
        checks++; if (ready !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL full_ready got ready=%0b count=%0d exp 0/4", ready, count); end
        tick();
        samp();
        checks++; if (count !== 3'd4 || ready !== 1'b0) begin errors++; $display("FAIL full_reject got count=%0d ready=%0b exp 4/0", count, ready); end
        tick();
        valid = 1'b0;
        hold  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            samp();
            checks++; if (we !== 1'b1 || waddr !== AW'(k)) begin errors++; $display("FAIL drain_seq%0d got we=%0b addr=%0d exp 1/%0d", k, we, waddr, k); end
            tick();
        end
        samp();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got empty=%0b exp 1", empty); end
    endtask

    task automatic test_forward();
        hold = 1'b1;
        offer(5'd7, 32'h11);
        tick();
        offer(5'd7, 32'h22);
        tick();
        offer(5'd9, 32'h99);
        ra1 = 5'd7;
        ra2 = 5'd9;
        samp();
        checks++; if (hit1 !== 1'b1 || fwd1 !== 32'h22) begin errors++; $display("FAIL fwd_youngest got hit1=%0b fwd1=%h exp 1/22", hit1, fwd1); end
        checks++; if (hit2 !== 1'b0 || fwd2 !== '0) begin errors++; $display("FAIL fwd_offered got hit2=%0b fwd2=%h exp 0/0", hit2, fwd2); end
        tick();
        valid = 1'b0;
        samp();
        checks++; if (hit2 !== 1'b1 || fwd2 !== 32'h99) begin errors++; $display("FAIL fwd_stored got hit2=%0b fwd2=%h exp 1/99", hit2, fwd2); end
        ra2 = 5'd0;
        #1;
        checks++; if (hit2 !== 1'b0 || fwd2 !== '0) begin errors++; $display("FAIL fwd_r0 got hit2=%0b fwd2=%h exp 0/0", hit2, fwd2); end
        tick();
        hold = 1'b0;
        samp();
        checks++; if (we !== 1'b1 || hit1 !== 1'b1 || fwd1 !== 32'h22) begin errors++; $display("FAIL fwd_drain1 got we=%0b hit1=%0b fwd1=%h exp 1/1/22", we, hit1, fwd1); end
        tick();
        samp();
        checks++; if (we !== 1'b1 || waddr !== 5'd7 || hit1 !== 1'b1 || fwd1 !== 32'h22) begin errors++; $display("FAIL fwd_head got we=%0b addr=%0d hit1=%0b fwd1=%h exp 1/7/1/22", we, waddr, hit1, fwd1); end
        tick();
        samp();
        checks++; if (hit1 !== 1'b0 || fwd1 !== '0) begin errors++; $display("FAIL fwd_gone got hit1=%0b fwd1=%h exp 0/0", hit1, fwd1); end
        tick();
        ra1 = '0;
        samp();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwd_empty got empty=%0b exp 1", empty); end
    endtask

    task automatic test_addr_zero();
        tick();
        offer(5'd0, 32'hFFFF);
        samp();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%0b exp 1", ready); end
        tick();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            samp();
            checks++; if (count !== 3'd0 || we !== 1'b0) begin errors++; $display("FAIL zero_discard got count=%0d we=%0b exp 0/0", count, we); end
            tick();
        end
    endtask

    task automatic test_wrap();
        int acc0;
        int wr0;
        acc0 = accepted;
        wr0  = written;
        hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            offer(AW'(i + 20), $urandom);
            tick();
        end
        hold = 1'b0;
        offer(5'd30, $urandom);
        samp();
        checks++; if (ready !== 1'b0 || we !== 1'b1) begin errors++; $display("FAIL full_pop_ready got ready=%0b we=%0b exp 0/1", ready, we); end
        tick();
        for (int i = 0; i < 19; i++) begin
            offer(AW'((i % 31) + 1), $urandom);
            tick();
        end
        valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            samp();
            if (empty) break;
            tick();
        end
        checks++; if (empty !== 1'b1 || sb.size() != 0) begin errors++; $display("FAIL wrap_drain got empty=%0b pending=%0d exp 1/0", empty, sb.size()); end
        checks++; if ((accepted - acc0) <= 2 * DEPTH || (written - wr0) != (accepted - acc0)) begin errors++; $display("FAIL wrap_count got accepted=%0d written=%0d exp >%0d and equal", accepted - acc0, written - wr0, 2 * DEPTH); end
    endtask

    task automatic test_reset_pending();
        tick();
        hold = 1'b1;
        offer(5'd10, 32'hA0);
        tick();
        offer(5'd11, 32'hA1);
        tick();
        offer(5'd12, 32'hA2);
        tick();
        valid = 1'b0;
        ra1 = 5'd11;
        ra2 = 5'd12;
        samp();
        checks++; if (count !== 3'd3 || hit1 !== 1'b1 || fwd2 !== 32'hA2) begin errors++; $display("FAIL rstp_pre got count=%0d hit1=%0b fwd2=%h exp 3/1/a2", count, hit1, fwd2); end
        tick();
        rst = 1'b1;
        offer(5'd13, 32'hA3);
        tick();
        rst   = 1'b0;
        valid = 1'b0;
        hold  = 1'b0;
        sb.delete();
        samp();
        checks++; if (count !== 3'd0 || we !== 1'b0) begin errors++; $display("FAIL rstp_state got count=%0d we=%0b exp 0/0", count, we); end
        checks++; if (hit1 !== 1'b0 || hit2 !== 1'b0) begin errors++; $display("FAIL rstp_hit got hit1=%0b hit2=%0b exp 0/0", hit1, hit2); end
        tick();
        samp();
        checks++; if (we !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rstp_dropped got we=%0b empty=%0b exp 0/1", we, empty); end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; hold = 1'b0; addr = '0; data = '0; ra1 = '0; ra2 = '0;
        test_reset();
        test_single();
        test_hold_full();
        test_forward();
        test_addr_zero();
        test_wrap();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
